// File: rtl/mult_seq_if.sv
// mult_seq_if: start/busy/done handshake and operand/result bus for mult_seq.
//   master modport: drives start, A, B; observes busy, done, Product, Result, Overflow.
//   slave modport : the multiplier side (inverse directions).
//   W: operand width (2..32).
interface mult_seq_if #(
    parameter int W = 4
) ();
    logic             start;
    logic [W-1:0]     A;
    logic [W-1:0]     B;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   Product;
    logic [W-1:0]     Result;
    logic             Overflow;

    modport master (
        output start, A, B,
        input  busy, done, Product, Result, Overflow
    );

    modport slave (
        input  start, A, B,
        output busy, done, Product, Result, Overflow
    );
endinterface

// File: rtl/mult_seq.sv
// mult_seq: sequential shift-add multiplier, one partial product per cycle.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset (aborts any operation, clears outputs)
//   bus  - mult_seq_if.slave: start/A/B in; busy/done/Product/Result/Overflow out
//
// Optional feature macro: MULT_SEQ_SIGNED_EN
//   defined   - two's complement operands (magnitude core + final negate),
//               Overflow when Product[2W-1:W-1] is not all-equal
//   undefined - unsigned operands, Overflow when Product[2W-1:W] is nonzero
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; outputs hold the last result
// RUN   | iterating, one multiplier bit per cycle (W cycles)
// DONE  | one-cycle done pulse; start here is accepted back-to-back
module mult_seq #(
    parameter int W = 4
) (
    input  logic       clk,
    input  logic       rst,
    mult_seq_if.slave  bus
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_nxt;
    logic              accept, last;

    logic [W-1:0]      mcand, mplier;
    logic [2*W:0]      acc;
    logic [CW-1:0]     cnt;

    logic [W-1:0]      a_mag, b_mag;
    logic [W:0]        upper_sum;
    logic [2*W:0]      acc_nxt;
    logic [2*W-1:0]    prod_nxt;
    logic              ovf_nxt;

    logic              busy_q, done_q, ovf_q;
    logic [2*W-1:0]    prod_q;
    logic [W-1:0]      res_q;

`ifdef MULT_SEQ_SIGNED_EN
    logic              sign, sign_in;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = RUN;
                    accept    = 1'b1;
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    state_nxt = DONE;
                    last      = 1'b1;
                end
            end
            DONE: begin
                if (bus.start) begin
                    state_nxt = RUN;
                    accept    = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Add the multiplicand into the upper half, then shift the whole
    // accumulator right; after W steps acc[2W-1:0] holds the product.
    always_comb begin
        upper_sum = acc[2*W:W] + (mplier[0] ? {1'b0, mcand} : {(W+1){1'b0}});
        acc_nxt   = {upper_sum, acc[W-1:0]} >> 1;
    end

`ifdef MULT_SEQ_SIGNED_EN
    always_comb begin
        a_mag    = bus.A[W-1] ? (~bus.A + 1'b1) : bus.A;
        b_mag    = bus.B[W-1] ? (~bus.B + 1'b1) : bus.B;
        sign_in  = bus.A[W-1] ^ bus.B[W-1];
        prod_nxt = sign ? (~acc_nxt[2*W-1:0] + 1'b1) : acc_nxt[2*W-1:0];
        // Representable in W signed bits iff bits 2W-1..W-1 are all equal.
        ovf_nxt  = !((&prod_nxt[2*W-1:W-1]) || !(|prod_nxt[2*W-1:W-1]));
    end
`else
    always_comb begin
        a_mag    = bus.A;
        b_mag    = bus.B;
        prod_nxt = acc_nxt[2*W-1:0];
        ovf_nxt  = |prod_nxt[2*W-1:W];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            prod_q <= '0;
            res_q  <= '0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
`ifdef MULT_SEQ_SIGNED_EN
            sign   <= 1'b0;
`endif
        end else begin
            if (accept) begin
                mcand  <= a_mag;
                mplier <= b_mag;
                acc    <= '0;
                cnt    <= CW'(W - 1);
`ifdef MULT_SEQ_SIGNED_EN
                sign   <= sign_in;
`endif
            end else if (state == RUN) begin
                acc    <= acc_nxt;
                mplier <= mplier >> 1;
                if (cnt != '0) cnt <= cnt - 1'b1;
            end
            if (last) begin
                prod_q <= prod_nxt;
                res_q  <= prod_nxt[W-1:0];
                ovf_q  <= ovf_nxt;
            end
            // Flags follow the next state so they are true register outputs.
            busy_q <= (state_nxt == RUN);
            done_q <= (state_nxt == DONE);
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.Product  = prod_q;
    assign bus.Result   = res_q;
    assign bus.Overflow = ovf_q;
endmodule

// File: tb/tb_mult_seq.sv
module tb_mult_seq;
    localparam int W = 4;

`ifdef MULT_SEQ_SIGNED_EN
    localparam logic OVF_SMALL = 1'b1;   // 14 and 15 exceed signed 4-bit range
`else
    localparam logic OVF_SMALL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult_seq_if #(.W(W)) bus ();
    mult_seq #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present operands with start for one edge; returns just after the accepting edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.A = a;
        bus.B = b;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.A = '0;
        bus.B = '0;
        cyc(2);
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %0b want 0", bus.done); end
        n_cmp++; if (bus.Product !== 8'h00) begin n_err++; $display("FAIL reset_product: got %h want 00", bus.Product); end
        n_cmp++; if (bus.Result !== 4'h0) begin n_err++; $display("FAIL reset_result: got %h want 0", bus.Result); end
        n_cmp++; if (bus.Overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %0b want 0", bus.Overflow); end
        bus.start = 1'b1;
        bus.A = 4'd3;
        bus.B = 4'd3;
        cyc();
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_priority_busy: got %0b want 0", bus.busy); end
        bus.start = 1'b0;
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_basic();
        issue(4'd3, 4'd5);
        for (int i = 0; i < W; i++) begin
            n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL basic_busy[%0d]: got %0b want 1", i, bus.busy); end
            n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL basic_done_early[%0d]: got %0b want 0", i, bus.done); end
            cyc();
        end
        n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL basic_done: got %0b want 1", bus.done); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_at_done: got %0b want 0", bus.busy); end
        n_cmp++; if (bus.Product !== 8'h0F) begin n_err++; $display("FAIL basic_product: got %h want 0f", bus.Product); end
        n_cmp++; if (bus.Result !== 4'hF) begin n_err++; $display("FAIL basic_result: got %h want f", bus.Result); end
        n_cmp++; if (bus.Overflow !== OVF_SMALL) begin n_err++; $display("FAIL basic_overflow: got %0b want %0b", bus.Overflow, OVF_SMALL); end
        cyc();
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse: got %0b want 0", bus.done); end
        n_cmp++; if (bus.Product !== 8'h0F) begin n_err++; $display("FAIL basic_hold: got %h want 0f", bus.Product); end
    endtask

    task automatic test_ignore_start();
        int dones = 0;
        logic [2*W-1:0] seen = '0;
        issue(4'd3, 4'd5);
        for (int i = 0; i < 12; i++) begin
            if (i == 1) begin
                bus.start = 1'b1;
                bus.A = 4'd15;
                bus.B = 4'd15;
            end
            if (i == 2) bus.start = 1'b0;
            cyc();
            if (bus.done === 1'b1) begin
                dones++;
                seen = bus.Product;
            end
        end
        n_cmp++; if (dones != 1) begin n_err++; $display("FAIL ignore_done_count: got %0d want 1", dones); end
        n_cmp++; if (seen !== 8'h0F) begin n_err++; $display("FAIL ignore_product: got %h want 0f", seen); end
    endtask

    task automatic test_abort();
        int dones = 0;
        issue(4'd2, 4'd3);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %0b want 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL abort_done: got %0b want 0", bus.done); end
        n_cmp++; if (bus.Product !== 8'h00) begin n_err++; $display("FAIL abort_product: got %h want 00", bus.Product); end
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (bus.done === 1'b1) dones++;
        end
        n_cmp++; if (dones != 0) begin n_err++; $display("FAIL abort_no_done: got %0d want 0", dones); end
        issue(4'd2, 4'd3);
        cyc(W);
        n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL abort_restart_done: got %0b want 1", bus.done); end
        n_cmp++; if (bus.Product !== 8'h06) begin n_err++; $display("FAIL abort_restart_product: got %h want 06", bus.Product); end
        n_cmp++; if (bus.Overflow !== 1'b0) begin n_err++; $display("FAIL abort_restart_overflow: got %0b want 0", bus.Overflow); end
        cyc();
    endtask

    task automatic test_back_to_back();
        issue(4'd0, 4'd9);
        cyc(2);
        n_cmp++; if (bus.Product !== 8'h06) begin n_err++; $display("FAIL b2b_hold_while_busy: got %h want 06", bus.Product); end
        cyc(W - 2);
        n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL b2b_zero_done: got %0b want 1", bus.done); end
        n_cmp++; if (bus.Product !== 8'h00) begin n_err++; $display("FAIL b2b_zero_product: got %h want 00", bus.Product); end
        n_cmp++; if (bus.Overflow !== 1'b0) begin n_err++; $display("FAIL b2b_zero_overflow: got %0b want 0", bus.Overflow); end
        bus.start = 1'b1;
        bus.A = 4'd2;
        bus.B = 4'd7;
        cyc();
        bus.start = 1'b0;
        n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept_busy: got %0b want 1", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL b2b_accept_done: got %0b want 0", bus.done); end
        cyc(W);
        n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL b2b_second_done: got %0b want 1", bus.done); end
        n_cmp++; if (bus.Product !== 8'h0E) begin n_err++; $display("FAIL b2b_second_product: got %h want 0e", bus.Product); end
        n_cmp++; if (bus.Overflow !== OVF_SMALL) begin n_err++; $display("FAIL b2b_second_overflow: got %0b want %0b", bus.Overflow, OVF_SMALL); end
        cyc();
    endtask

`ifndef MULT_SEQ_SIGNED_EN
    task automatic test_max_hold();
        issue(4'd15, 4'd15);
        cyc(W);
        n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL max_done: got %0b want 1", bus.done); end
        n_cmp++; if (bus.Product !== 8'hE1) begin n_err++; $display("FAIL max_product: got %h want e1", bus.Product); end
        n_cmp++; if (bus.Result !== 4'h1) begin n_err++; $display("FAIL max_result: got %h want 1", bus.Result); end
        n_cmp++; if (bus.Overflow !== 1'b1) begin n_err++; $display("FAIL max_overflow: got %0b want 1", bus.Overflow); end
        cyc(5);
        n_cmp++; if (bus.Product !== 8'hE1) begin n_err++; $display("FAIL max_hold_product: got %h want e1", bus.Product); end
        n_cmp++; if (bus.Overflow !== 1'b1) begin n_err++; $display("FAIL max_hold_overflow: got %0b want 1", bus.Overflow); end
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL max_hold_done: got %0b want 0", bus.done); end
    endtask
`else
    task automatic test_signed();
        issue(4'h8, 4'h8);
        cyc(W);
        n_cmp++; if (bus.Product !== 8'h40) begin n_err++; $display("FAIL signed_m8m8_product: got %h want 40", bus.Product); end
        n_cmp++; if (bus.Result !== 4'h0) begin n_err++; $display("FAIL signed_m8m8_result: got %h want 0", bus.Result); end
        n_cmp++; if (bus.Overflow !== 1'b1) begin n_err++; $display("FAIL signed_m8m8_overflow: got %0b want 1", bus.Overflow); end
        cyc();
        issue(4'hE, 4'h3);
        cyc(W);
        n_cmp++; if (bus.Product !== 8'hFA) begin n_err++; $display("FAIL signed_m2p3_product: got %h want fa", bus.Product); end
        n_cmp++; if (bus.Result !== 4'hA) begin n_err++; $display("FAIL signed_m2p3_result: got %h want a", bus.Result); end
        n_cmp++; if (bus.Overflow !== 1'b0) begin n_err++; $display("FAIL signed_m2p3_overflow: got %0b want 0", bus.Overflow); end
        cyc();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_ignore_start();
        test_abort();
        test_back_to_back();
`ifndef MULT_SEQ_SIGNED_EN
        test_max_hold();
`else
        test_signed();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
